// File: rtl/lcd_pkg.sv
// Shared definitions for the 16x2 HD44780 character LCD driver.
// Holds the controller command bytes, the sequencer and byte-writer state
// encodings, and small helpers that pick the init command and a
// character out of a packed 128-bit line.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;  // auto-increment address
  localparam logic [7:0] ADDR_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] ADDR_LINE2    = 8'hC0;  // DDRAM address 0x40

  // Index of the last command in the power-up sequence.
  localparam logic [2:0] INIT_LAST = 3'd5;

  // Sequencer states. Each byte-sending state is the state in which that
  // byte is on the bus; the byte was launched on entry to the state.
  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_SNAP,
    ST_ADDR1,
    ST_CHAR1,
    ST_ADDR2,
    ST_CHAR2,
    ST_FEND
  } lcd_state_e;

  // Phases of a single byte write.
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_EN_HIGH,
    WR_WAIT
  } wr_phase_e;

  // Power-up command sequence: three function-set writes, display on,
  // clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_8B2L;
      3'd3:             cmd = CMD_DISP_ON;
      3'd4:             cmd = CMD_CLEAR;
      default:          cmd = CMD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

  // Character idx of a line; char 0 (leftmost) sits in bits [7:0].
  function automatic logic [7:0] char_at(input logic [127:0] line,
                                         input logic [3:0]   idx);
    return line[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the LCD bus with controller-safe strobe timing:
//   SETUP   2 cycles, lcd_en low, rs/data driven
//   EN_HIGH T_EN_HIGH cycles, lcd_en high
//   WAIT    T_CLEAR cycles after a clear command, else T_CMD cycles
// lcd_rs/lcd_data hold until the next byte is launched. All outputs are
// registered so the LCD pins never see combinational glitches.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            launch a byte (accepted when idle or when done is high)
//   rs, data         register select and byte for the launched write
//   is_clear         launched byte is the clear command (selects T_CLEAR)
//   done             high in the last WAIT cycle; a start in that cycle
//                    chains the next byte with no idle gap
//   lcd_rs, lcd_en, lcd_data   LCD bus
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2_500,
  parameter int T_CLEAR   = 100_000,
  parameter int TIMER_W   = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       is_clear,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [TIMER_W-1:0] ONE     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_SETUP = TIMER_W'(2);

  wr_phase_e          phase_q, phase_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               clear_q, clear_d;
  logic               rs_q,    rs_d;
  logic [7:0]         data_q,  data_d;
  logic               en_q,    en_d;

  always_comb begin
    // NOTE: every signal gets a default before the case; a path that left
    // one unassigned would infer a latch.
    phase_d = phase_q;
    timer_d = timer_q;
    clear_d = clear_q;
    rs_d    = rs_q;
    data_d  = data_q;

    unique case (phase_q)
      WR_IDLE: timer_d = timer_q;
      WR_SETUP: begin
        if (timer_q == ONE) begin
          phase_d = WR_EN_HIGH;
          timer_d = TIMER_W'(T_EN_HIGH);
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      WR_EN_HIGH: begin
        if (timer_q == ONE) begin
          phase_d = WR_WAIT;
          timer_d = clear_q ? TIMER_W'(T_CLEAR) : TIMER_W'(T_CMD);
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      WR_WAIT: begin
        if (timer_q == ONE) phase_d = WR_IDLE;
        timer_d = timer_q - ONE;
      end
    endcase

    // A launch overrides the phase update so a chained byte starts
    // directly out of the final WAIT cycle.
    if (start) begin
      phase_d = WR_SETUP;
      timer_d = T_SETUP;
      rs_d    = rs;
      data_d  = data;
      clear_d = is_clear;
    end

    en_d = (phase_d == WR_EN_HIGH);
  end

  assign done = (phase_q == WR_WAIT) && (timer_q == ONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= WR_IDLE;
      timer_q <= '0;
      clear_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      clear_q <= clear_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_driver_16x2.sv
// 16x2 HD44780 character LCD driver, 8-bit write-only mode.
// After reset waits T_POWERUP cycles, sends the init sequence
// (38 38 38 0C 01 06), raises pronto, then writes frames forever:
// snapshot both lines, 0x80, 16 line-1 chars, 0xC0, 16 line-2 chars,
// one-cycle frame_done. The snapshot keeps a frame consistent even if the
// message changes while it is being written.
//
// Optional build macro REFRESH_ON_CHANGE_EN: after the first frame the
// driver idles in SNAP until linha1/linha2 differ from the snapshot, then
// writes one frame. Without it frames repeat back-to-back.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   linha1, linha2     line characters, char k at [8k+7:8k], k=0 leftmost
//   lcd_rs             0 = command, 1 = data
//   lcd_rw             tied 0 (write only)
//   lcd_en             enable strobe
//   lcd_data           LCD data bus
//   pronto             high once initialisation has completed
//   frame_done         one-cycle pulse after the last line-2 byte's wait
module lcd_driver_16x2
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 1_000_000,
  parameter int T_EN_HIGH = 25,
  parameter int T_CMD     = 2_500,
  parameter int T_CLEAR   = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] linha1,
  input  logic [127:0] linha2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         pronto,
  output logic         frame_done
);

  localparam int T_MAX_A = (T_POWERUP > T_EN_HIGH) ? T_POWERUP : T_EN_HIGH;
  localparam int T_MAX_B = (T_CMD > T_CLEAR) ? T_CMD : T_CLEAR;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TIMER_W = $clog2(T_MAX) + 1;

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  lcd_state_e         state_q, state_d;
  logic [TIMER_W-1:0] pwr_timer_q, pwr_timer_d;
  logic [2:0]         init_idx_q, init_idx_d;
  logic [3:0]         char_idx_q, char_idx_d;
  logic [127:0]       snap1_q, snap1_d;
  logic [127:0]       snap2_q, snap2_d;
  logic               pronto_q, pronto_d;
  logic               frame_done_q, frame_done_d;

  logic               take_snap;
`ifdef REFRESH_ON_CHANGE_EN
  logic               frame_seen_q, frame_seen_d;
`endif

  logic               wr_start;
  logic               wr_rs;
  logic [7:0]         wr_data;
  logic               wr_is_clear;
  logic               wr_done;

  lcd_byte_writer #(
    .T_EN_HIGH (T_EN_HIGH),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR),
    .TIMER_W   (TIMER_W)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .is_clear (wr_is_clear),
    .done     (wr_done),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  // Only a command 0x01 is a clear; a data byte 0x01 is an ordinary char.
  assign wr_is_clear = !wr_rs && (wr_data == CMD_CLEAR);

`ifdef REFRESH_ON_CHANGE_EN
  assign take_snap = !frame_seen_q || (linha1 != snap1_q) || (linha2 != snap2_q);
`else
  assign take_snap = 1'b1;
`endif

  // Each byte is launched on the cycle its predecessor's wait expires
  // (wr_done), so the sequencer always computes the *next* byte here.
  always_comb begin
    state_d      = state_q;
    pwr_timer_d  = pwr_timer_q;
    init_idx_d   = init_idx_q;
    char_idx_d   = char_idx_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    pronto_d     = pronto_q;
    frame_done_d = 1'b0;
`ifdef REFRESH_ON_CHANGE_EN
    frame_seen_d = frame_seen_q;
`endif
    wr_start     = 1'b0;
    wr_rs        = 1'b0;
    wr_data      = 8'h00;

    unique case (state_q)
      ST_POWERUP: begin
        if (pwr_timer_q == ONE) begin
          wr_start   = 1'b1;
          wr_data    = init_cmd(3'd0);
          init_idx_d = 3'd0;
          state_d    = ST_INIT;
        end else begin
          pwr_timer_d = pwr_timer_q - ONE;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (init_idx_q == INIT_LAST) begin
            pronto_d = 1'b1;
            state_d  = ST_SNAP;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            wr_start   = 1'b1;
            wr_data    = init_cmd(init_idx_q + 3'd1);
          end
        end
      end
      ST_SNAP: begin
        // The line address does not depend on the snapshot, so it is
        // launched in the same cycle the snapshot is taken.
        if (take_snap) begin
          snap1_d  = linha1;
          snap2_d  = linha2;
          wr_start = 1'b1;
          wr_data  = ADDR_LINE1;
          state_d  = ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        if (wr_done) begin
          wr_start   = 1'b1;
          wr_rs      = 1'b1;
          wr_data    = char_at(snap1_q, 4'd0);
          char_idx_d = 4'd0;
          state_d    = ST_CHAR1;
        end
      end
      ST_CHAR1: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (char_idx_q == 4'd15) begin
            wr_data = ADDR_LINE2;
            state_d = ST_ADDR2;
          end else begin
            wr_rs      = 1'b1;
            wr_data    = char_at(snap1_q, char_idx_q + 4'd1);
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      ST_ADDR2: begin
        if (wr_done) begin
          wr_start   = 1'b1;
          wr_rs      = 1'b1;
          wr_data    = char_at(snap2_q, 4'd0);
          char_idx_d = 4'd0;
          state_d    = ST_CHAR2;
        end
      end
      ST_CHAR2: begin
        if (wr_done) begin
          if (char_idx_q == 4'd15) begin
            // Registered, so the pulse lands on the FEND cycle itself.
            frame_done_d = 1'b1;
            state_d      = ST_FEND;
          end else begin
            wr_start   = 1'b1;
            wr_rs      = 1'b1;
            wr_data    = char_at(snap2_q, char_idx_q + 4'd1);
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      ST_FEND: begin
`ifdef REFRESH_ON_CHANGE_EN
        frame_seen_d = 1'b1;
`endif
        state_d = ST_SNAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_POWERUP;
      pwr_timer_q  <= TIMER_W'(T_POWERUP);
      init_idx_q   <= 3'd0;
      char_idx_q   <= 4'd0;
      // NOTE: the snapshot is a plain register bank, not a RAM, so it is
      // reset like any other flop and never exposes X on the bus.
      snap1_q      <= '0;
      snap2_q      <= '0;
      pronto_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef REFRESH_ON_CHANGE_EN
      frame_seen_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pwr_timer_q  <= pwr_timer_d;
      init_idx_q   <= init_idx_d;
      char_idx_q   <= char_idx_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      pronto_q     <= pronto_d;
      frame_done_q <= frame_done_d;
`ifdef REFRESH_ON_CHANGE_EN
      frame_seen_q <= frame_seen_d;
`endif
    end
  end

  assign lcd_rw     = 1'b0;
  assign pronto     = pronto_q;
  assign frame_done = frame_done_q;

endmodule
